// File: rtl/iobuf_bank_pkg.sv
// rtl/iobuf_bank_pkg.sv - shared types and constants for the I/O pad-bank controller
package iobuf_bank_pkg;

    typedef enum logic [1:0] {
        ST_RX      = 2'd0,
        ST_TURN_TX = 2'd1,
        ST_TX      = 2'd2,
        ST_TURN_RX = 2'd3
    } state_t;

    localparam int TURN_CNT_W      = 4;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int FILL_W          = $clog2(SYNC_STAGES_MAX + 1);

endpackage

// File: rtl/iobuf_sync.sv
// rtl/iobuf_sync.sv - multi-stage receive synchroniser flop chain
module iobuf_sync
    import iobuf_bank_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_pipe [SYNC_STAGES];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_q = r_pipe[SYNC_STAGES-1];

    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            assert (SYNC_STAGES >= 2 && SYNC_STAGES <= SYNC_STAGES_MAX)
                else $error("iobuf_sync: SYNC_STAGES out of range");
        end
    end

endmodule

// File: rtl/iobuf_bank_ctrl.sv
// rtl/iobuf_bank_ctrl.sv - bidirectional pad bank with turnaround dead cycles
// Optional even-parity pad and receive parity check under IOBUF_BANK_PARITY_EN.
module iobuf_bank_ctrl
    import iobuf_bank_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int TURN_CYCLES = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
`ifdef IOBUF_BANK_PARITY_EN
    inout  wire  [WIDTH:0]   io_pad,
    output logic             o_rx_parity_err,
`else
    inout  wire  [WIDTH-1:0] io_pad,
`endif
    input  logic [WIDTH-1:0] i_tx_data,
    input  logic             i_tx_valid,
    output logic             o_tx_ready,
    output logic [WIDTH-1:0] o_rx_data,
    output logic             o_rx_valid,
    output logic             o_bus_dir
);

`ifdef IOBUF_BANK_PARITY_EN
    localparam int PAD_W = WIDTH + 1;
`else
    localparam int PAD_W = WIDTH;
`endif

    localparam logic [TURN_CNT_W-1:0] TURN_LAST = TURN_CNT_W'(TURN_CYCLES - 1);
    localparam logic [FILL_W-1:0]     FILL_FULL = FILL_W'(SYNC_STAGES);

    state_t                  r_state;
    state_t                  w_next;
    logic [TURN_CNT_W-1:0]   r_turn_cnt;
    logic [FILL_W-1:0]       r_fill;
    logic [WIDTH-1:0]        r_out;
    logic                    w_turn_last;
    logic                    w_load;
    logic [PAD_W-1:0]        w_pad_drive;
    logic [PAD_W-1:0]        w_sync;

    assign w_turn_last = (r_turn_cnt == TURN_LAST);

    // Ready in TURN_TX is qualified by valid so an abandoned request never handshakes.
    always_comb begin
        w_next     = r_state;
        o_tx_ready = 1'b0;
        w_load     = 1'b0;
        case (r_state)
            ST_RX: begin
                if (i_tx_valid) w_next = ST_TURN_TX;
            end
            ST_TURN_TX: begin
                if (w_turn_last) begin
                    o_tx_ready = i_tx_valid;
                    w_load     = i_tx_valid;
                    w_next     = i_tx_valid ? ST_TX : ST_TURN_RX;
                end
            end
            ST_TX: begin
                o_tx_ready = 1'b1;
                w_load     = i_tx_valid;
                if (!i_tx_valid) w_next = ST_TURN_RX;
            end
            ST_TURN_RX: begin
                if (w_turn_last) w_next = ST_RX;
            end
            default: w_next = ST_RX;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ST_RX;
            r_turn_cnt <= '0;
            r_fill     <= '0;
            r_out      <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_turn_cnt <= '0;
            end else if (r_state == ST_TURN_TX || r_state == ST_TURN_RX) begin
                r_turn_cnt <= r_turn_cnt + 1'b1;
            end
            // Fill restarts on every RX entry so rx_valid waits for a fresh pipe.
            if (r_state == ST_RX && w_next == ST_RX) begin
                if (r_fill != FILL_FULL) r_fill <= r_fill + 1'b1;
            end else begin
                r_fill <= '0;
            end
            if (w_load) r_out <= i_tx_data;
        end
    end

`ifdef IOBUF_BANK_PARITY_EN
    assign w_pad_drive = {^r_out, r_out};
`else
    assign w_pad_drive = r_out;
`endif

    assign io_pad = (r_state == ST_TX) ? w_pad_drive : {PAD_W{1'bz}};

    iobuf_sync #(
        .WIDTH       (PAD_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (io_pad),
        .o_q     (w_sync)
    );

    assign o_rx_data  = w_sync[WIDTH-1:0];
    assign o_rx_valid = (r_state == ST_RX) && (r_fill == FILL_FULL);
    assign o_bus_dir  = (r_state == ST_TX);

`ifdef IOBUF_BANK_PARITY_EN
    assign o_rx_parity_err = o_rx_valid & (^w_sync);
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            assert (TURN_CYCLES >= 1 && TURN_CYCLES <= 15)
                else $error("iobuf_bank_ctrl: TURN_CYCLES must be 1..15");
        end
    end

endmodule

// File: tb/tb_iobuf_bank_ctrl.sv
// tb/tb_iobuf_bank_ctrl.sv - directed self-checking bench for iobuf_bank_ctrl
module tb_iobuf_bank_ctrl;

    localparam int WIDTH = 8;
`ifdef IOBUF_BANK_PARITY_EN
    localparam int PW = WIDTH + 1;
`else
    localparam int PW = WIDTH;
`endif

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             bus_dir;
    logic             tb_en;
    logic [PW-1:0]    tb_val;
    wire  [PW-1:0]    pad;
`ifdef IOBUF_BANK_PARITY_EN
    logic             parity_err;
`endif

    int total;
    int bad;

    assign pad = tb_en ? tb_val : {PW{1'bz}};

    iobuf_bank_ctrl #(
        .WIDTH       (WIDTH),
        .TURN_CYCLES (3),
        .SYNC_STAGES (2)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
`ifdef IOBUF_BANK_PARITY_EN
        .io_pad          (pad),
        .o_rx_parity_err (parity_err),
`else
        .io_pad          (pad),
`endif
        .i_tx_data       (tx_data),
        .i_tx_valid      (tx_valid),
        .o_tx_ready      (tx_ready),
        .o_rx_data       (rx_data),
        .o_rx_valid      (rx_valid),
        .o_bus_dir       (bus_dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (tb_en) chk("no_overlap", 32'(bus_dir), 32'd0);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        tb_en    = 1'b1;
        tb_val   = PW'(8'hA5);

        // 1: reset and receive fill
        tick();
        chk("rst_tx_ready", 32'(tx_ready), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data",  32'(rx_data),  32'd0);
        chk("rst_bus_dir",  32'(bus_dir),  32'd0);
        rst_n = 1'b1;
        tick();
        chk("fill1_rx_valid", 32'(rx_valid), 32'd0);
        tick();
        chk("fill2_rx_valid", 32'(rx_valid), 32'd1);
        chk("fill2_rx_data",  32'(rx_data),  32'hA5);
        chk("fill2_bus_dir",  32'(bus_dir),  32'd0);
`ifdef IOBUF_BANK_PARITY_EN
        chk("fill2_par_err", 32'(parity_err), 32'd0);
`endif

        // 2: turnaround then streaming
        tx_valid = 1'b1;
        tx_data  = 8'h11;
        tick();
        tb_en = 1'b0;
        chk("ttx0_bus_dir",  32'(bus_dir),  32'd0);
        chk("ttx0_rx_valid", 32'(rx_valid), 32'd0);
        chk("ttx0_ready",    32'(tx_ready), 32'd0);
        tick();
        chk("ttx1_bus_dir", 32'(bus_dir),  32'd0);
        chk("ttx1_ready",   32'(tx_ready), 32'd0);
        tick();
        chk("ttx2_bus_dir", 32'(bus_dir),  32'd0);
        chk("ttx2_ready",   32'(tx_ready), 32'd1);
        tick();
        chk("tx11_bus_dir", 32'(bus_dir),  32'd1);
        chk("tx11_pad",     32'(pad[WIDTH-1:0]), 32'h11);
        chk("tx11_ready",   32'(tx_ready), 32'd1);
        tx_data = 8'h22;
        tick();
        chk("tx22_pad", 32'(pad[WIDTH-1:0]), 32'h22);
        tx_data = 8'h33;
        tick();
        chk("tx33_pad",     32'(pad[WIDTH-1:0]), 32'h33);
        chk("tx33_bus_dir", 32'(bus_dir), 32'd1);
        tx_valid = 1'b0;

        // 3: release and return to receive
        tick();
        chk("trx0_bus_dir", 32'(bus_dir),  32'd0);
        chk("trx0_ready",   32'(tx_ready), 32'd0);
        tb_en  = 1'b1;
        tb_val = PW'(8'hC3);
        tick();
        chk("trx1_bus_dir", 32'(bus_dir), 32'd0);
        tick();
        chk("trx2_bus_dir", 32'(bus_dir), 32'd0);
        tick();
        chk("rx0_rx_valid", 32'(rx_valid), 32'd0);
        tick();
        chk("rx1_rx_valid", 32'(rx_valid), 32'd0);
        tick();
        chk("rx2_rx_valid", 32'(rx_valid), 32'd1);
        chk("rx2_rx_data",  32'(rx_data),  32'hC3);

        // 4: abandoned request during TURN_TX
        tx_valid = 1'b1;
        tx_data  = 8'h77;
        tick();
        tx_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("abort_ready",   32'(tx_ready), 32'd0);
            chk("abort_bus_dir", 32'(bus_dir),  32'd0);
            tick();
        end
        chk("abort_rx0_valid", 32'(rx_valid), 32'd0);
        tick();
        chk("abort_rx1_valid", 32'(rx_valid), 32'd0);
        tick();
        chk("abort_rx2_valid", 32'(rx_valid), 32'd1);

        // 5: reset while streaming
        tx_valid = 1'b1;
        tx_data  = 8'h5A;
        tick();
        tb_en = 1'b0;
        tick();
        tick();
        tick();
        chk("s5a_bus_dir", 32'(bus_dir), 32'd1);
        chk("s5a_pad",     32'(pad[WIDTH-1:0]), 32'h5A);
        rst_n = 1'b0;
        tick();
        chk("mrst_bus_dir",  32'(bus_dir),  32'd0);
        chk("mrst_ready",    32'(tx_ready), 32'd0);
        chk("mrst_rx_valid", 32'(rx_valid), 32'd0);
        chk("mrst_rx_data",  32'(rx_data),  32'd0);
        rst_n    = 1'b1;
        tx_valid = 1'b0;
        tb_en    = 1'b1;
        tb_val   = PW'(8'hA5);
        tick();
        tick();
        chk("post_rst_rx_valid", 32'(rx_valid), 32'd1);

`ifdef IOBUF_BANK_PARITY_EN
        // 6: parity drive and receive check
        tx_valid = 1'b1;
        tx_data  = 8'h07;
        tick();
        tb_en = 1'b0;
        tick();
        tick();
        tick();
        chk("par_tx_pad", 32'(pad), 32'h107);
        tx_valid = 1'b0;
        tick();
        tb_en  = 1'b1;
        tb_val = 9'h103;
        for (int i = 0; i < 5; i++) tick();
        chk("par_rx_valid", 32'(rx_valid),   32'd1);
        chk("par_rx_err",   32'(parity_err), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
